dump_tx: RTL and testbench
==========================

# dump_tx

Serial dump transmitter sitting directly downstream of the capture/dump controller. It consumes the controller's `send_dump`/`dump_sent` handshake, latches the RAM read byte presented during the dump, and shifts it out as one 8N1 UART frame on `tx`. It pulses `dump_sent` once the stop bit completes, so the controller can advance the dump address. A dump byte counter is kept for status readback.

## Interface
- `BAUD_DIV`, default 434: clk cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- `clk`  in  1  system clock; all state on posedge.
- `rst_n`  in  1  asynchronous active-low reset.
- `send_dump`  in  1  byte-valid request from the dump controller; held high until `dump_sent`.
- `rdata`  in  8  RAM read data; valid whenever `send_dump` is high.
- `dump_finished`  in  1  one-cycle pulse from the controller at the end of the trace.
- `tx`  out  1  UART serial line, idle high.
- `dump_sent`  out  1  one-cycle registered pulse: byte fully transmitted.
- `busy`  out  1  high from byte latch until the `dump_sent` cycle inclusive.
- `dump_cnt`  out  10  bytes sent since the last `dump_finished` or reset.

## Operation
- States: IDLE, START, DATA, STOP, DONE.
- Reset values: state IDLE, `tx`=1, `dump_sent`=0, `busy`=0, `dump_cnt`=0, `rearm`=1, shift register 0, baud counter 0, bit index 0.
- `rearm` flag: cleared on latch, set in any cycle `send_dump` is low. Latch requires `rearm`=1. This blocks a double send if `send_dump` lingers after `dump_sent`.
- IDLE: if `send_dump && rearm`, latch `rdata` into the shift register, clear the baud counter, go to START. Otherwise stay, with `tx`=1.
- START: `tx`=0 for BAUD_DIV cycles, then go to DATA with bit index 0.
- DATA: `tx`=shift[0], LSB first. Each bit lasts BAUD_DIV cycles, then shift right and increment the bit index. After bit 7 go to STOP.
- STOP: `tx`=1 for BAUD_DIV cycles, then go to DONE.
- DONE: one cycle. `dump_sent`=1, `dump_cnt` += 1 (wraps 1023→0), return to IDLE.
- `tx` is a registered output. It never glitches and is 1 in IDLE and DONE.
- `rdata` changes after the latch have no effect on the frame in flight.
- `dump_finished` clears `dump_cnt` to 0. When it coincides with DONE, the clear wins (count reads 0).
- `send_dump` falling mid-frame (protocol violation): the frame completes and `dump_sent` still pulses.
- Reset asserted mid-frame: all registers return to reset values asynchronously; `tx` goes high immediately. No `dump_sent` is produced for the aborted byte.
- Baud counter: width ceil(log2(BAUD_DIV)) bits; counts 0..BAUD_DIV-1. The bit ends on the cycle the counter equals BAUD_DIV-1.

## Timing
- `send_dump` sampled high in IDLE at edge N: `tx` falls after edge N+1 (first START cycle).
- Frame length is exactly 10·BAUD_DIV cycles: START + 8 DATA + STOP.
- `dump_sent` is high for the single cycle after the last STOP cycle, i.e. cycle N+1+10·BAUD_DIV.
- The controller drops `send_dump` combinationally in the `dump_sent` cycle, so `rearm` is set no later than the following cycle.
- Minimum spacing between frames: tx stays high for at least 1 cycle (DONE) plus the controller's re-read cycles.
- `busy` is asserted from cycle N+1 through the DONE cycle inclusive.

## Structure
- Shared package `dump_pkg`:
  - state typedef `TxState` {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE};
  - `DUMP_CNT_W`=10;
  - `UART_BITS`=8.
- One sub-module, `uart_tx_core`:
  - contents: baud counter, shift register and bit index;
  - ports: `clk`, `rst_n`, `load`, `din[7:0]`, `tx`, `frame_done`.
- `dump_tx` owns the handshake FSM, the `rearm` flag and `dump_cnt`.
- Expected size: about 200 lines total.

## Test plan
- Single byte, BAUD_DIV=4, `rdata`=8'hA5:
  - `tx` shows 0, then 1,0,1,0,0,1,0,1, then 1, each bit held 4 cycles;
  - `dump_sent` pulses once at cycle N+41;
  - `dump_cnt`=1.
- Lingering request: hold `send_dump` high for 5 cycles after `dump_sent` → no second frame starts; `tx` stays 1; `dump_cnt` stays 1.
- Back-to-back dump of 3 bytes 8'h00/8'hFF/8'h3C through the controller-style handshake → 3 correct frames, 3 `dump_sent` pulses, `dump_cnt`=3.
- `dump_finished` coincident with DONE after 5 bytes → `dump_cnt`=0 on the next cycle; `dump_sent` still pulses.
- Reset pulsed during DATA bit 3 → `tx`=1 immediately, `dump_sent` never asserts, `busy`=0. A new `send_dump` then produces a full clean frame.
- `rdata` toggled every cycle during the frame with a latched value of 8'h81 → transmitted bits are 1,0,0,0,0,0,0,1 (LSB first).

Source files
------------

// File: rtl/dump_pkg.sv
// Shared types and constants for the serial dump transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dump_pkg;

  // Frame phases. The top-level handshake FSM uses IDLE/START/DONE, with
  // START covering the whole frame in flight. The UART core sequences
  // START/DATA/STOP on its own.
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_DONE
  } TxState;

  localparam int DUMP_CNT_W = 10;
  localparam int UART_BITS  = 8;

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 UART shifter: baud counter, shift register and bit index.
// Latency: tx falls one cycle after load; frame_done pulses on the last STOP cycle edge.
// Backpressure: none; load is only honoured while the core is idle.
//
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   load        - capture din and start a frame (ignored unless idle)
//   din[7:0]    - byte to send, sampled only on load
//   tx          - registered serial line, idle high
//   frame_done  - one-cycle pulse when the stop bit period has elapsed
module uart_tx_core
  import dump_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] din,
  output logic       tx,
  output logic       frame_done
);

  localparam int                CNT_W    = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [2:0]        BIT_LAST = 3'(UART_BITS - 1);

  TxState           r_phase;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit;
  logic             r_tx;
  logic             r_frame_done;

  logic w_bit_end;
  assign w_bit_end = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase      <= TX_IDLE;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_bit        <= '0;
      r_tx         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;

      // tx is the registered image of the current phase, so the line lags
      // the phase by one cycle; every bit still lasts exactly BAUD_DIV cycles.
      if (r_phase == TX_START) begin
        r_tx <= 1'b0;
      end else if (r_phase == TX_DATA) begin
        r_tx <= r_shift[0];
      end else begin
        r_tx <= 1'b1;
      end

      case (r_phase)
        TX_IDLE: begin
          if (load) begin
            r_shift <= din;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_phase <= TX_START;
          end
        end
        TX_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_phase <= TX_DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        TX_DATA: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bit == BIT_LAST) begin
              r_phase <= TX_STOP;
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        TX_STOP: begin
          if (w_bit_end) begin
            r_cnt        <= '0;
            r_phase      <= TX_IDLE;
            r_frame_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_phase <= TX_IDLE;
      endcase
    end
  end

  assign tx         = r_tx;
  assign frame_done = r_frame_done;

endmodule

// File: rtl/dump_tx.sv
// Dump transmitter: send_dump/dump_sent handshake around a UART 8N1 core.
// Latency: tx falls 1 cycle after the latch edge; dump_sent 10*BAUD_DIV+1 cycles after it.
// Backpressure: send_dump is held by the controller until dump_sent; rearm blocks re-sends.
//
// Ports:
//   clk, rst_n     - clock, async active-low reset
//   send_dump      - byte request, held high until dump_sent
//   rdata[7:0]     - byte to send, latched when the request is accepted
//   dump_finished  - pulse that clears dump_cnt (wins over an increment)
//   tx             - UART line, idle high
//   dump_sent      - one-cycle pulse after the stop bit
//   busy           - high from latch through the dump_sent cycle
//   dump_cnt[9:0]  - bytes sent since reset or last dump_finished
module dump_tx
  import dump_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  send_dump,
  input  logic [7:0]            rdata,
  input  logic                  dump_finished,
  output logic                  tx,
  output logic                  dump_sent,
  output logic                  busy,
  output logic [DUMP_CNT_W-1:0] dump_cnt
);

  TxState                r_state;
  logic                  r_rearm;
  logic                  r_busy;
  logic                  r_dump_sent;
  logic [DUMP_CNT_W-1:0] r_dump_cnt;

  logic w_latch;
  logic w_frame_done;

  // A request is accepted only after send_dump has been seen low since the
  // previous accept, so a request lingering past dump_sent cannot resend.
  assign w_latch = (r_state == TX_IDLE) && send_dump && r_rearm;

  uart_tx_core #(
    .BAUD_DIV (BAUD_DIV)
  ) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (w_latch),
    .din        (rdata),
    .tx         (tx),
    .frame_done (w_frame_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= TX_IDLE;
      r_rearm     <= 1'b1;
      r_busy      <= 1'b0;
      r_dump_sent <= 1'b0;
      r_dump_cnt  <= '0;
    end else begin
      r_dump_sent <= 1'b0;

      if (!send_dump) begin
        r_rearm <= 1'b1;
      end else if (w_latch) begin
        r_rearm <= 1'b0;
      end

      case (r_state)
        TX_IDLE: begin
          if (w_latch) begin
            r_state <= TX_START;
            r_busy  <= 1'b1;
          end
        end
        // Frame in flight; the core owns the START/DATA/STOP sequencing.
        TX_START: begin
          if (w_frame_done) begin
            r_state     <= TX_DONE;
            r_dump_sent <= 1'b1;
          end
        end
        TX_DONE: begin
          r_state    <= TX_IDLE;
          r_busy     <= 1'b0;
          r_dump_cnt <= r_dump_cnt + DUMP_CNT_W'(1);
        end
        default: r_state <= TX_IDLE;
      endcase

      // Placed last so a coincident clear overrides the DONE increment.
      if (dump_finished) begin
        r_dump_cnt <= '0;
      end
    end
  end

  assign dump_sent = r_dump_sent;
  assign busy      = r_busy;
  assign dump_cnt  = r_dump_cnt;

endmodule

// File: tb/tb_dump_tx.sv
module tb_dump_tx;

  localparam int BAUD = 4;

  logic       clk;
  logic       rst_n;
  logic       send_dump;
  logic [7:0] rdata;
  logic       dump_finished;
  logic       tx;
  logic       dump_sent;
  logic       busy;
  logic [9:0] dump_cnt;

  int errors;
  int checks;
  int exp_cnt;

  dump_tx #(.BAUD_DIV(BAUD)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .send_dump     (send_dump),
    .rdata         (rdata),
    .dump_finished (dump_finished),
    .tx            (tx),
    .dump_sent     (dump_sent),
    .busy          (busy),
    .dump_cnt      (dump_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level for frame slot: 0 start, 1..8 data LSB first, 9 stop.
  function automatic logic exp_bit(input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    else if (slot <= 8) return b[slot-1];
    else return 1'b1;
  endfunction

  // Controller-style single byte transfer with full frame checking.
  task automatic run_frame(input logic [7:0] b, input bit toggle, input bit linger, input bit fin);
    int pulses;
    pulses = 0;
    @(negedge clk);
    send_dump = 1'b1;
    rdata     = b;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL latch_cycle_tx: got %b want 1", tx);
    end
    for (int k = 0; k < 10*BAUD; k++) begin
      if (toggle) rdata = 8'($urandom);
      @(negedge clk);
      checks++;
      if (tx !== exp_bit(b, k / BAUD)) begin
        errors++;
        $display("FAIL frame_bit byte=%h k=%0d: got %b want %b", b, k, tx, exp_bit(b, k / BAUD));
      end
      if (dump_sent === 1'b1) pulses++;
      if (k == 5*BAUD) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_midframe: got %b want 1", busy);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (dump_sent !== 1'b1) begin
      errors++;
      $display("FAIL dump_sent_timing byte=%h: got %b want 1", b, dump_sent);
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL dump_sent_early: got %0d pulses want 0", pulses);
    end
    checks++;
    if (tx !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL done_cycle: got tx=%b busy=%b want tx=1 busy=1", tx, busy);
    end
    if (fin) dump_finished = 1'b1;
    if (!linger) send_dump = 1'b0;
    exp_cnt = fin ? 0 : (exp_cnt + 1) % 1024;
    @(negedge clk);
    dump_finished = 1'b0;
    checks++;
    if (dump_sent !== 1'b0) begin
      errors++;
      $display("FAIL dump_sent_width: got %b want 0", dump_sent);
    end
    checks++;
    if (dump_cnt !== 10'(exp_cnt)) begin
      errors++;
      $display("FAIL dump_cnt_after_frame: got %0d want %0d", dump_cnt, exp_cnt);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_done: got %b want 0", busy);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || dump_sent !== 1'b0 || busy !== 1'b0 || dump_cnt !== 10'd0) begin
      errors++;
      $display("FAIL reset_state: got tx=%b sent=%b busy=%b cnt=%0d want 1 0 0 0",
               tx, dump_sent, busy, dump_cnt);
    end
    rst_n = 1'b1;
    exp_cnt = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single;
    run_frame(8'hA5, 1'b0, 1'b1, 1'b0);
  endtask

  // Continues from test_single with send_dump still high.
  task automatic test_linger;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || dump_sent !== 1'b0) begin
        errors++;
        $display("FAIL linger_no_resend i=%0d: got tx=%b busy=%b sent=%b want 1 0 0",
                 i, tx, busy, dump_sent);
      end
    end
    send_dump = 1'b0;
    @(negedge clk);
    checks++;
    if (dump_cnt !== 10'(exp_cnt)) begin
      errors++;
      $display("FAIL linger_cnt: got %0d want %0d", dump_cnt, exp_cnt);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [3];
    bytes[0] = 8'h00;
    bytes[1] = 8'hFF;
    bytes[2] = 8'h3C;
    for (int i = 0; i < 3; i++) run_frame(bytes[i], 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_rdata_toggle;
    run_frame(8'h81, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_frame(8'($urandom), 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_finish_clear;
    @(negedge clk);
    dump_finished = 1'b1;
    @(negedge clk);
    dump_finished = 1'b0;
    exp_cnt = 0;
    checks++;
    if (dump_cnt !== 10'd0) begin
      errors++;
      $display("FAIL finish_clear: got %0d want 0", dump_cnt);
    end
    for (int i = 0; i < 4; i++) run_frame(8'($urandom), 1'b0, 1'b0, 1'b0);
    checks++;
    if (dump_cnt !== 10'd4) begin
      errors++;
      $display("FAIL cnt_before_finish: got %0d want 4", dump_cnt);
    end
    run_frame(8'($urandom), 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_midframe;
    logic [7:0] b;
    bit         seen;
    bit         tx_bad;
    b = 8'($urandom) & 8'hF7;
    @(negedge clk);
    send_dump = 1'b1;
    rdata     = b;
    @(negedge clk);
    // Run into the middle of data bit 3 (slot 4).
    for (int k = 0; k < 4*BAUD + 2; k++) begin
      @(negedge clk);
      checks++;
      if (tx !== exp_bit(b, k / BAUD)) begin
        errors++;
        $display("FAIL pre_reset_bit k=%0d: got %b want %b", k, tx, exp_bit(b, k / BAUD));
      end
    end
    #2;
    rst_n     = 1'b0;
    send_dump = 1'b0;
    #1;
    exp_cnt = 0;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || dump_sent !== 1'b0 || dump_cnt !== 10'd0) begin
      errors++;
      $display("FAIL async_reset: got tx=%b busy=%b sent=%b cnt=%0d want 1 0 0 0",
               tx, busy, dump_sent, dump_cnt);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    seen   = 1'b0;
    tx_bad = 1'b0;
    repeat (12*BAUD) begin
      @(negedge clk);
      if (dump_sent !== 1'b0) seen = 1'b1;
      if (tx !== 1'b1) tx_bad = 1'b1;
    end
    checks++;
    if (seen || tx_bad) begin
      errors++;
      $display("FAIL aborted_frame: got sent_seen=%b tx_low_seen=%b want 0 0", seen, tx_bad);
    end
    run_frame(8'($urandom), 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    exp_cnt       = 0;
    rst_n         = 1'b0;
    send_dump     = 1'b0;
    rdata         = 8'h00;
    dump_finished = 1'b0;
    test_reset();
    test_single();
    test_linger();
    test_back_to_back();
    test_rdata_toggle();
    test_random();
    test_finish_clear();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
